// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port valid/ready arbiter for the data memory with per-port response buffers
module dmem_arbiter #(
    parameter int DEPTH     = 8,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [15:0] req_addr0,
    input  logic [15:0] req_addr1,
    input  logic [15:0] req_wdata0,
    input  logic [15:0] req_wdata1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [1:0]  rsp_err,
    output logic [15:0] rsp_rdata0,
    output logic [15:0] rsp_rdata1,
    output logic        mem_wr_en,
    output logic        mem_read_en,
    output logic [15:0] mem_Addr,
    output logic [15:0] mem_wr_data,
    input  logic [15:0] mem_rd_data
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [1:0]    r_rsp_valid, r_rsp_err;
    logic [15:0]   r_rdata0, r_rdata1;
    logic          r_last;
    logic [WW-1:0] r_wait;
    logic [1:0]    w_elig, w_grant;
    logic          w_sel, w_we, w_oor, w_any;
    logic [15:0]   w_addr, w_wdata, w_rdata;

    always_comb begin
        w_elig  = rst ? 2'b00 : req_valid & (~r_rsp_valid | rsp_ready);
        w_sel   = (PRIO_MODE == 0) ? ~r_last : (r_wait == WW'(MAX_WAIT));
        w_grant = (&w_elig) ? (w_sel ? 2'b10 : 2'b01) : w_elig;
        w_any   = |w_grant;
        w_addr  = w_grant[1] ? req_addr1 : req_addr0;
        w_wdata = w_grant[1] ? req_wdata1 : req_wdata0;
        w_we    = w_grant[1] ? req_we[1] : req_we[0];
        w_oor   = w_addr >= 16'(DEPTH);
        w_rdata = (!w_oor && !w_we) ? mem_rd_data : 16'h0;
    end

    assign req_ready   = w_grant;
    assign mem_Addr    = w_any ? w_addr : 16'h0;
    assign mem_wr_data = w_any ? w_wdata : 16'h0;
    assign mem_wr_en   = w_any & !w_oor & w_we;
    assign mem_read_en = w_any & !w_oor & !w_we;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata0  = r_rdata0;
    assign rsp_rdata1  = r_rdata1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 2'b00;
            r_rdata0    <= 16'h0;
            r_rdata1    <= 16'h0;
            r_last      <= 1'b1;
            r_wait      <= '0;
        end else begin
            if (w_any) r_last <= w_grant[1];
            r_wait <= (w_elig[1] && !w_grant[1]) ? ((r_wait == WW'(MAX_WAIT)) ? r_wait : r_wait + WW'(1)) : '0;
            if (w_grant[0]) begin
                r_rsp_valid[0] <= 1'b1;
                r_rsp_err[0]   <= w_oor;
                r_rdata0       <= w_rdata;
            end else if (rsp_ready[0]) begin
                r_rsp_valid[0] <= 1'b0;
                r_rsp_err[0]   <= 1'b0;
            end
            if (w_grant[1]) begin
                r_rsp_valid[1] <= 1'b1;
                r_rsp_err[1]   <= w_oor;
                r_rdata1       <= w_rdata;
            end else if (rsp_ready[1]) begin
                r_rsp_valid[1] <= 1'b0;
                r_rsp_err[1]   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of round-robin and fixed-priority arbiter instances
module tb_dmem_arbiter;
    logic        clk = 0, rst = 1, seed = 1;
    logic [1:0]  req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic [1:0]  rr_req_ready, rr_rsp_valid, rr_rsp_err, fp_req_ready, fp_rsp_valid, fp_rsp_err;
    logic [15:0] rr_rdata0, rr_rdata1, rr_addr, rr_wdata, rr_mrd;
    logic [15:0] fp_rdata0, fp_rdata1, fp_addr, fp_wdata, fp_mrd;
    logic        rr_wr_en, rr_rd_en, fp_wr_en, fp_rd_en;
    logic [15:0] mem_rr [8];
    logic [15:0] mem_fp [8];
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(8), .PRIO_MODE(0), .MAX_WAIT(4)) u_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_req_ready), .req_we(req_we),
        .req_addr0(addr0), .req_addr1(addr1), .req_wdata0(wdata0), .req_wdata1(wdata1),
        .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rr_rsp_err),
        .rsp_rdata0(rr_rdata0), .rsp_rdata1(rr_rdata1), .mem_wr_en(rr_wr_en), .mem_read_en(rr_rd_en),
        .mem_Addr(rr_addr), .mem_wr_data(rr_wdata), .mem_rd_data(rr_mrd));

    dmem_arbiter #(.DEPTH(8), .PRIO_MODE(1), .MAX_WAIT(4)) u_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready), .req_we(req_we),
        .req_addr0(addr0), .req_addr1(addr1), .req_wdata0(wdata0), .req_wdata1(wdata1),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_err(fp_rsp_err),
        .rsp_rdata0(fp_rdata0), .rsp_rdata1(fp_rdata1), .mem_wr_en(fp_wr_en), .mem_read_en(fp_rd_en),
        .mem_Addr(fp_addr), .mem_wr_data(fp_wdata), .mem_rd_data(fp_mrd));

    always @(posedge clk) begin
        if (seed) begin
            for (int i = 0; i < 8; i++) begin
                mem_rr[i] <= 16'h1000 + 16'(i);
                mem_fp[i] <= 16'h1000 + 16'(i);
            end
        end else begin
            if (rr_wr_en) mem_rr[rr_addr[2:0]] <= rr_wdata;
            if (fp_wr_en) mem_fp[fp_addr[2:0]] <= fp_wdata;
        end
    end
    assign rr_mrd = mem_rr[rr_addr[2:0]];
    assign fp_mrd = mem_fp[fp_addr[2:0]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tick;
        tick;
        seed = 0;
        req_valid = 2'b11; req_we = 2'b11; addr0 = 3; addr1 = 4; wdata0 = 16'hAAAA; wdata1 = 16'hBBBB;
        #1;
        chk("rst_req_ready", 16'(rr_req_ready), 0);
        chk("rst_wr_en", 16'(rr_wr_en), 0);
        chk("rst_mem_addr", rr_addr, 0);
        chk("rst_fp_req_ready", 16'(fp_req_ready), 0);
        tick;
        chk("rst_rsp_valid", 16'(rr_rsp_valid), 0);
        chk("rst_rdata0", rr_rdata0, 0);
        rst = 0;
        req_valid = 2'b01; req_we = 2'b01; addr0 = 3; wdata0 = 16'hBEEF; rsp_ready = 2'b11;
        #1;
        chk("wr_req_ready", 16'(rr_req_ready), 16'h1);
        chk("wr_en", 16'(rr_wr_en), 1);
        chk("wr_addr", rr_addr, 3);
        chk("wr_data", rr_wdata, 16'hBEEF);
        tick;
        chk("wr_ack_valid", 16'(rr_rsp_valid), 16'h1);
        chk("wr_ack_rdata", rr_rdata0, 0);
        req_we = 2'b00;
        #1;
        chk("rd_read_en", 16'(rr_rd_en), 1);
        chk("rd_req_ready", 16'(rr_req_ready), 16'h1);
        tick;
        chk("raw_rdata0", rr_rdata0, 16'hBEEF);
        chk("raw_err", 16'(rr_rsp_err), 0);
        req_valid = 2'b00;
        tick;
        chk("idle_rsp_valid", 16'(rr_rsp_valid), 0);
        rst = 1;
        tick;
        rst = 0;
        req_valid = 2'b11; req_we = 2'b00; addr0 = 1; addr1 = 2;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 16'(rr_req_ready), (k % 2 == 0) ? 16'h1 : 16'h2);
            chk("fp_grant", 16'(fp_req_ready), (k == 4) ? 16'h2 : 16'h1);
            tick;
            chk("rr_rsp_valid", 16'(rr_rsp_valid), (k % 2 == 0) ? 16'h1 : 16'h2);
            chk("rr_rdata", (k % 2 == 0) ? rr_rdata0 : rr_rdata1, (k % 2 == 0) ? 16'h1001 : 16'h1002);
        end
        req_valid = 2'b00;
        tick;
        req_valid = 2'b10; req_we = 2'b10; addr1 = 16'h0008; wdata1 = 16'h1234;
        #1;
        chk("oor_req_ready", 16'(rr_req_ready), 16'h2);
        chk("oor_wr_en", 16'(rr_wr_en), 0);
        chk("oor_rd_en", 16'(rr_rd_en), 0);
        tick;
        chk("oor_err", 16'(rr_rsp_err), 16'h2);
        chk("oor_valid", 16'(rr_rsp_valid), 16'h2);
        chk("oor_rdata1", rr_rdata1, 0);
        req_we = 2'b00; addr1 = 0;
        tick;
        chk("oor_readback", rr_rdata1, 16'h1000);
        chk("oor_readback_err", 16'(rr_rsp_err), 0);
        req_valid = 2'b01; addr0 = 1;
        tick;
        chk("stall_setup_valid", 16'(rr_rsp_valid), 16'h1);
        rsp_ready = 2'b10; req_valid = 2'b11; addr0 = 4; addr1 = 2;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_grant", 16'(rr_req_ready), 16'h2);
            tick;
            chk("stall_rdata0", rr_rdata0, 16'h1001);
            chk("stall_valid", 16'(rr_rsp_valid), 16'h3);
        end
        rsp_ready = 2'b11;
        #1;
        chk("unstall_grant", 16'(rr_req_ready), 16'h1);
        tick;
        chk("unstall_rdata0", rr_rdata0, 16'h1004);
        chk("unstall_valid", 16'(rr_rsp_valid), 16'h1);
        rsp_ready = 2'b00;
        #1;
        chk("fill_grant", 16'(rr_req_ready), 16'h2);
        tick;
        chk("fill_valid", 16'(rr_rsp_valid), 16'h3);
        rst = 1; req_we = 2'b11; addr0 = 5; addr1 = 5; wdata0 = 16'hDEAD; wdata1 = 16'hDEAD;
        #1;
        chk("rst2_req_ready", 16'(rr_req_ready), 0);
        chk("rst2_wr_en", 16'(rr_wr_en), 0);
        tick;
        chk("rst2_rsp_valid", 16'(rr_rsp_valid), 0);
        rst = 0; req_we = 2'b00; rsp_ready = 2'b11; addr0 = 1; addr1 = 2;
        #1;
        chk("post_rst_tie", 16'(rr_req_ready), 16'h1);
        tick;
        chk("post_rst_valid", 16'(rr_rsp_valid), 16'h1);
        req_valid = 2'b01; addr0 = 5;
        tick;
        chk("rst2_readback", rr_rdata0, 16'h1005);
        req_valid = 2'b00;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
